// File: rtl/uart_rx_axis_packer.sv
// rtl/uart_rx_axis_packer.sv - UART byte FIFO with AXI-Stream packetised output
//
// Buffers bytes from a UART receiver in a first-word-fall-through FIFO. The
// FIFO output is presented as an AXI-Stream master, and tlast marks every
// PKT_LEN-th beat. A byte that arrives while the FIFO is full is dropped.
// A drop sets a sticky flag and increments a saturating counter.
//
// Ports:
//   clk, rst         clock (rising edge); asynchronous active-high reset
//   in_data/in_valid received byte and its one-cycle strobe (no backpressure)
//   m_axis_*         stream output: tdata, tvalid, tready, tlast
//   fill_level       current FIFO occupancy, 0..DEPTH
//   overflow         sticky flag: at least one byte dropped
//   drop_count       dropped-byte count, saturates at 255
//   clear_overflow   one-cycle clear of overflow and drop_count

module uart_rx_axis_packer #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int PKT_LEN   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_BITS-1:0]     in_data,
    input  logic                     in_valid,
    output logic [DATA_BITS-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [BW-1:0]        beat_cnt;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic last_beat;

    // Each pointer has one extra wrap bit. When the pointers are equal, the FIFO is empty.
    // When the indices match and the wrap bits differ, the FIFO is full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop  = !empty && m_axis_tready;
    // If a pop frees a slot in the same cycle, a push into a full FIFO is still accepted.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign last_beat = (beat_cnt == BW'(PKT_LEN - 1));

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = mem[rd_ptr[AW-1:0]];
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign fill_level    = wr_ptr - rd_ptr;

    // The storage array has no reset. Entries are only observable between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (last_beat) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // If a clear and a drop happen in the same cycle, the drop wins.
    // The result is a fresh count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (clear_overflow) begin
            overflow   <= drop;
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/uart_rx_axis_packer.md
UART_RX_AXIS_PACKER -- requirements
Module: uart_rx_axis_packer

Interface
REQ-001 The block SHALL have these parameters:
- DATA_BITS, 8, byte width; matches the upstream receiver.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- PKT_LEN, 4, output beats per AXI-Stream packet; minimum 1.

REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  DATA_BITS  received byte from the UART receiver.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle; no backpressure.
- m_axis_tdata  out  DATA_BITS  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the packet.
- fill_level  out  $clog2(DEPTH)+1  current number of FIFO entries.
- overflow  out  1  sticky; at least one byte dropped.
- drop_count  out  8  dropped-byte count; saturates at 255.
- clear_overflow  in  1  one-cycle clear of overflow and drop_count.

Function
REQ-003 The block SHALL buffer bytes in a first-word-fall-through FIFO of DEPTH entries, using read/write pointers with one extra wrap bit.
REQ-004 push = in_valid && (!full || pop); pop = m_axis_tvalid && m_axis_tready.
REQ-005 m_axis_tvalid SHALL equal !empty, and m_axis_tdata SHALL equal the FIFO head entry.
REQ-006 Latency: if in_valid is asserted in cycle N with the FIFO empty, m_axis_tvalid SHALL be 1 in cycle N+1 with that byte on m_axis_tdata.
REQ-007 m_axis_tdata and m_axis_tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-008 Empty FIFO: pop SHALL be 0, and m_axis_tready SHALL have no effect.
REQ-009 Full FIFO with pop in the same cycle: the incoming byte SHALL be accepted, and fill_level SHALL stay DEPTH.
REQ-010 Push and pop in the same cycle (not empty): fill_level SHALL be unchanged.
REQ-011 Pointer wrap: pointers SHALL wrap modulo 2*DEPTH; full = same index with differing wrap bit; empty = equal pointers.
REQ-012 Beat counter: 0..PKT_LEN-1; increments on pop; wraps to 0 on the pop where it equals PKT_LEN-1.
REQ-013 m_axis_tlast = m_axis_tvalid && (beat_cnt == PKT_LEN-1); with PKT_LEN=1, every beat carries tlast.
REQ-014 Drop rule: in_valid && full && !pop SHALL discard in_data, set overflow=1, and increment drop_count (saturating at 255).
REQ-015 clear_overflow SHALL clear overflow and drop_count on the next edge.
REQ-016 clear_overflow coinciding with a drop: the result SHALL be overflow=1, drop_count=1.
REQ-017 A drop SHALL NOT alter FIFO contents, pointers or beat counter.

Reset
REQ-018 On rst assertion, the block SHALL immediately clear both pointers, beat_cnt, overflow and drop_count.
REQ-019 While rst is high, outputs SHALL be m_axis_tvalid=0, m_axis_tlast=0, fill_level=0, overflow=0, drop_count=0; m_axis_tdata is don't-care.
REQ-020 Reset mid-packet or mid-handshake SHALL discard all buffered bytes; the first pop after reset SHALL be beat 0.
REQ-021 The first push after rst deasserts SHALL be accepted on the first clk edge.

Verification
REQ-022 Single byte: tready=1, strobe 0xA5 in cycle N -> tvalid=1 and tdata=0xA5 in cycle N+1; tvalid=0 in cycle N+2.
REQ-023 Packetising: PKT_LEN=4, strobe 0x01..0x08 with tready=1 -> tlast=1 only on 0x04 and 0x08, and the order is preserved.
REQ-024 Backpressure: tready=0, push 3 bytes -> fill_level=3 and tdata held at the first byte; then tready=1 -> 3 beats in order, fill_level=0.
REQ-025 Overflow: DEPTH=16, tready=0, push 18 bytes -> fill_level=16, overflow=1, drop_count=2, and bytes 1..16 are later drained intact.
REQ-026 Full push/pop and clear: with the FIFO full, push + pop in the same cycle -> no drop, fill_level=16; then clear_overflow + drop in the same cycle -> overflow=1, drop_count=1.
REQ-027 Async reset mid-packet: after 2 beats of a 4-beat packet, pulse rst between edges -> tvalid=0 immediately; the next packet's 4th beat carries tlast.
